// File: rtl/router_pkg.sv
// Shared defaults for the router output-channel FIFO.
// Holds the default geometry and header length-field position.
package router_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;
  localparam int LEN_LSB_DEF    = 2;

endpackage

// File: rtl/router_fifo_pkt_if.sv
// Write/read bundle between router FSM, FIFO and destination port.
// master: drives requests; slave: the FIFO, returns data and flags.
interface router_fifo_pkt_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                  write_enb;
  logic                  lfd_state;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_enb;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  pkt_end;
  logic                  parity_err;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [AW:0]           fill_level;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, data_valid, pkt_end, parity_err,
    input  empty, full, almost_full, fill_level
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, data_valid, pkt_end, parity_err,
    output empty, full, almost_full, fill_level
  );
endinterface

// File: rtl/router_fifo_mem.sv
// 1W/1R storage array, synchronous write, asynchronous read, no reset.
// Ports: clock, we/waddr/wdata (write), raddr/rdata (read).
module router_fifo_mem #(
  parameter int WIDTH      = 9,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO with header-driven pkt_end marking.
// Ports: clock, resetn (async), soft_reset (sync flush), bus (slave).
// Optional ROUTER_FIFO_PARITY_EN stores even parity per entry.
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int LEN_LSB      = LEN_LSB_DEF,
  parameter int LEN_MSB      = DATA_WIDTH - 1,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input logic               clock,
  input logic               resetn,
  input logic               soft_reset,
  router_fifo_pkt_if.slave  bus
);

  localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
  localparam int CNT_W = LEN_W + 1;

`ifdef ROUTER_FIFO_PARITY_EN
  typedef struct packed {
    logic                  hdr;
    logic                  par;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
`else
  typedef struct packed {
    logic                  hdr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
`endif

  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    pkt_cnt;
  logic                empty_w, full_w;
  logic                wr_acc, rd_acc;
  entry_t              wr_e, rd_e;

  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0])
                && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign wr_acc = bus.write_enb && !full_w && !soft_reset;
  assign rd_acc = bus.read_enb && !empty_w;

  always_comb begin
    wr_e      = '0;
    wr_e.hdr  = bus.lfd_state;
    wr_e.data = bus.data_in;
`ifdef ROUTER_FIFO_PARITY_EN
    wr_e.par  = ^bus.data_in;
`endif
  end

  router_fifo_mem #(
    .WIDTH      ($bits(entry_t)),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock (clock),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_e),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_e)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pkt_cnt        <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.pkt_end    <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pkt_cnt        <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.pkt_end    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr         <= rd_ptr + 1'b1;
        bus.data_out   <= rd_e.data;
        bus.data_valid <= 1'b1;
        if (rd_e.hdr) begin
          // length counts payload words; +1 covers the parity byte
          pkt_cnt     <= CNT_W'(rd_e.data[LEN_MSB:LEN_LSB])
                       + CNT_W'(1);
          bus.pkt_end <= 1'b0;
        end else begin
          bus.pkt_end <= (pkt_cnt == CNT_W'(1));
          if (pkt_cnt != '0) pkt_cnt <= pkt_cnt - 1'b1;
        end
      end else begin
        bus.data_valid <= 1'b0;
        bus.pkt_end    <= 1'b0;
      end
    end
  end

`ifdef ROUTER_FIFO_PARITY_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)         bus.parity_err <= 1'b0;
    else if (soft_reset) bus.parity_err <= 1'b0;
    else if (rd_acc)     bus.parity_err <= (^rd_e.data) != rd_e.par;
    else                 bus.parity_err <= 1'b0;
  end
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.fill_level  = wr_ptr - rd_ptr;
  assign bus.almost_full = bus.fill_level
                        >= (ADDR_WIDTH+1)'(AFULL_THRESH);

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Scoreboard bench for router_fifo_pkt against a queue-based model.
// Directed packet/boundary cases plus randomized traffic.
module tb_router_fifo_pkt;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic soft_reset = 1'b0;

  always #5 clock = ~clock;

  router_fifo_pkt_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

  router_fifo_pkt dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pr;
  } exp_t;

  logic [8:0] mq [$];
  exp_t       expq [$];
  int         mcnt = 0;
  bit         exp_perr = 0;
  int         ncmp = 0;
  int         nerr = 0;

  task automatic chk(input string name, input int act, input int want);
    ncmp++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  // Model: a plain queue of {hdr,data}; packet length counted in words.
  task automatic step(input bit we, input bit lfd,
                      input logic [7:0] din, input bit re,
                      input bit sr = 1'b0);
    bit rd_ok, wr_ok;
    logic [8:0] e;
    exp_t x;
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    bus.read_enb  = re;
    soft_reset    = sr;
    rd_ok = re && (mq.size() > 0);
    wr_ok = we && (mq.size() < 16);
    @(posedge clock);
    if (sr) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (rd_ok) begin
        e    = mq.pop_front();
        x.d  = e[7:0];
        x.pr = exp_perr;
        if (e[8]) begin
          mcnt = int'(e[7:2]) + 1;
          x.pe = 1'b0;
        end else begin
          x.pe = (mcnt == 1);
          if (mcnt > 0) mcnt--;
        end
        expq.push_back(x);
      end
      if (wr_ok) mq.push_back({lfd, din});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
  endtask

  task automatic do_reset();
    bus.write_enb = 0;
    bus.read_enb  = 0;
    resetn = 1'b0;
    mq.delete();
    expq.delete();
    mcnt = 0;
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_fill", bus.fill_level, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_afull", bus.almost_full, 0);
    @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (bus.data_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        x = expq.pop_front();
        chk("data_out", bus.data_out, x.d);
        chk("pkt_end", bus.pkt_end, x.pe);
        chk("parity_err", bus.parity_err, x.pr);
      end
    end else begin
      chk("missing_valid", expq.size(), 0);
      expq.delete();
      chk("idle_pkt_end", bus.pkt_end, 0);
    end
    chk("fill_level", bus.fill_level, mq.size());
    chk("empty", bus.empty, mq.size() == 0);
    chk("full", bus.full, mq.size() == 16);
    chk("almost_full", bus.almost_full, mq.size() >= 14);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.write_enb = 0;
    bus.lfd_state = 0;
    bus.data_in   = '0;
    bus.read_enb  = 0;
    #3;
    chk("init_empty", bus.empty, 1);
    chk("init_fill", bus.fill_level, 0);
    chk("init_valid", bus.data_valid, 0);
    @(posedge clock);
    #1 resetn = 1'b1;
    idle(2);

    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hA0 + i), 0);
    do_reset();
    idle(1);

    for (int i = 0; i < 17; i++) step(1, 0, 8'(i * 7 + 1), 0);
    step(1, 0, 8'hEE, 1);
    step(1, 0, 8'h55, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 8'h00, 1);
    step(1, 0, 8'h77, 1);
    idle(1);
    step(0, 0, 8'h00, 1);

    step(1, 1, 8'h0C, 0);
    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(1, 0, 8'h33, 0);
    step(1, 0, 8'h0C ^ 8'h11 ^ 8'h22 ^ 8'h33, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1);

    for (int i = 0; i < 7; i++) step(1, 0, 8'($urandom), 0);
    step(0, 0, 8'h00, 1, 1);
    idle(1);

`ifdef ROUTER_FIFO_PARITY_EN
    step(1, 0, 8'h35, 0);
    dut.u_mem.mem[0][0] = ~dut.u_mem.mem[0][0];
    mq[0][0] = ~mq[0][0];
    exp_perr = 1;
    step(0, 0, 8'h00, 1);
    exp_perr = 0;
    idle(1);
`endif

    for (int i = 0; i < 600; i++) begin
      bit we, re, lfd;
      int pw, pr;
      pw = (i < 300) ? 70 : 45;
      pr = (i < 300) ? 45 : 70;
      we  = $urandom_range(0, 99) < pw;
      re  = $urandom_range(0, 99) < pr;
      lfd = $urandom_range(0, 5) == 0;
      step(we, lfd, 8'($urandom), re);
    end

    while (mq.size() > 0) step(0, 0, 8'h00, 1);
    idle(2);
    chk("leftover_expect", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
